// File: rtl/decode_stage_ctrl_pkg.sv
// Shared definitions for the RV32I/M decode stage: opcodes, ALU/MDU
// operation codes, write-back source codes and the ID/EX control bundle.
package decode_stage_ctrl_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_SUB    = 5'b00000,
        ALU_ADD    = 5'b00001,
        ALU_AND    = 5'b00010,
        ALU_OR     = 5'b00011,
        ALU_XOR    = 5'b00100,
        ALU_SRL    = 5'b00101,
        ALU_SLL    = 5'b00110,
        ALU_SRA    = 5'b00111,
        ALU_SLT    = 5'b01000,
        ALU_SLTU   = 5'b01001,
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011,
        ALU_DIV    = 5'b10100,
        ALU_DIVU   = 5'b10101,
        ALU_REM    = 5'b10110,
        ALU_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MDR = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  branch;
        logic        jal;
        logic        jalr;
        logic        mem_read;
        logic        mem_write;
        wb_src_e     wb_src;
        alu_op_e     alu_op;
        logic        alu_src1;
        logic        alu_src2;
        logic        reg_write;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Integer ALU op from funct3; sub only exists for register-register ops.
    function automatic alu_op_e alu_fn(input logic [2:0] f3, input logic alt,
                                       input logic is_reg);
        alu_op_e op;
        case (f3)
            3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_ctrl_decode_comb.sv
// Pure combinational RV32I/M decoder.
// Ports: ir (instruction) -> ctrl (bundle, valid bit left 0), rs1_used,
// rs2_used, is_load, is_mul, is_div. EN_M = 0 turns M ops into illegals.
module decode_comb
    import decode_stage_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0] ir,
    output ctrl_t       ctrl,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        is_load,
    output logic        is_mul,
    output logic        is_div
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       known;
    logic       m_op;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign f7     = ir[31:25];

    always_comb begin
        ctrl          = '0;
        ctrl.rd       = ir[11:7];
        ctrl.rs1      = ir[19:15];
        ctrl.rs2      = ir[24:20];
        ctrl.branch   = {1'b0, f3};
        ctrl.alu_op   = ALU_ADD;
        ctrl.wb_src   = WB_ALU;
        ctrl.alu_src2 = 1'b1;
        rs1_used      = 1'b0;
        rs2_used      = 1'b0;
        known         = 1'b1;
        m_op          = 1'b0;

        case (opcode)
            LOAD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.wb_src    = WB_MDR;
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
            end
            STORE: begin
                ctrl.mem_write = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            BRANCH: begin
                ctrl.branch[3] = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.alu_src2  = 1'b0;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            JAL: begin
                ctrl.jal       = 1'b1;
                ctrl.wb_src    = WB_PC4;
                ctrl.reg_write = 1'b1;
            end
            JALR: begin
                ctrl.jalr      = 1'b1;
                ctrl.wb_src    = WB_PC4;
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
            end
            LUI: begin
                ctrl.reg_write = 1'b1;
            end
            AUIPC: begin
                ctrl.alu_src1  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP: begin
                ctrl.alu_src2  = 1'b0;
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                if (f7 == FUNCT7_M) begin
                    m_op        = 1'b1;
                    ctrl.alu_op = alu_op_e'({2'b10, f3});
                end else begin
                    ctrl.alu_op = alu_fn(f3, ir[30], 1'b1);
                end
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
                ctrl.alu_op    = alu_fn(f3, ir[30], 1'b0);
            end
            default: known = 1'b0;
        endcase

        ctrl.illegal = !known || (m_op && !EN_M);
        if (ctrl.illegal) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
        end
    end

    assign is_load = (opcode == LOAD);
    assign is_mul  = m_op && EN_M && !f3[2];
    assign is_div  = m_op && EN_M && f3[2];

endmodule

// File: rtl/decode_stage_ctrl.sv
// Registered RV32I/M decode stage between IF/ID and EX.
// Ports: clk, rstn (async active-low); ir_in/valid_in from IF/ID;
// stall_in (hold), flush_in (kill); ready_out back to fetch;
// ctrl_* = registered ID/EX control bundle.
module decode_stage_ctrl
    import decode_stage_ctrl_pkg::*;
#(
    parameter bit EN_M       = 1'b1,
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] ir_in,
    input  logic        valid_in,
    input  logic        stall_in,
    input  logic        flush_in,
    output logic        ready_out,
    output logic        ctrl_valid,
    output logic [3:0]  ctrl_branch,
    output logic        ctrl_jal,
    output logic        ctrl_jalr,
    output logic        ctrl_mem_read,
    output logic        ctrl_mem_write,
    output logic [1:0]  ctrl_wb_src,
    output logic [4:0]  ctrl_alu_op,
    output logic        ctrl_alu_src1,
    output logic        ctrl_alu_src2,
    output logic        ctrl_reg_write,
    output logic        ctrl_illegal,
    output logic [4:0]  ctrl_rd,
    output logic [4:0]  ctrl_rs1,
    output logic [4:0]  ctrl_rs2
);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    ctrl_t            dec;
    ctrl_t            ctrl_q;
    logic             rs1_used;
    logic             rs2_used;
    logic             is_load;
    logic             is_mul;
    logic             is_div;
    logic [CNT_W-1:0] cnt;
    logic             trk_valid;
    logic [4:0]       trk_rd;
    logic             load_use;

    decode_comb #(.EN_M(EN_M)) u_dec (
        .ir       (ir_in),
        .ctrl     (dec),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .is_load  (is_load),
        .is_mul   (is_mul),
        .is_div   (is_div)
    );

    assign load_use = trk_valid && (trk_rd != 5'd0) && valid_in &&
                      ((rs1_used && dec.rs1 == trk_rd) ||
                       (rs2_used && dec.rs2 == trk_rd));

    assign ready_out = !stall_in && (cnt == '0) && !load_use;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q    <= '0;
            cnt       <= '0;
            trk_valid <= 1'b0;
            trk_rd    <= '0;
        end else if (flush_in) begin
            ctrl_q    <= '0;
            cnt       <= '0;
            trk_valid <= 1'b0;
        end else if (stall_in) begin
            // ID/EX and tracker hold, but the EX unit keeps working.
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end else if (cnt != '0) begin
            ctrl_q <= '0;
            cnt    <= cnt - CNT_W'(1);
        end else if (load_use) begin
            ctrl_q    <= '0;
            trk_valid <= 1'b0;
        end else if (valid_in) begin
            ctrl_q       <= dec;
            ctrl_q.valid <= 1'b1;
            trk_valid    <= is_load && !dec.illegal;
            trk_rd       <= dec.rd;
            if (is_div)      cnt <= DIV_LOAD;
            else if (is_mul) cnt <= MUL_LOAD;
        end else begin
            ctrl_q    <= '0;
            trk_valid <= 1'b0;
        end
    end

    assign ctrl_valid     = ctrl_q.valid;
    assign ctrl_branch    = ctrl_q.branch;
    assign ctrl_jal       = ctrl_q.jal;
    assign ctrl_jalr      = ctrl_q.jalr;
    assign ctrl_mem_read  = ctrl_q.mem_read;
    assign ctrl_mem_write = ctrl_q.mem_write;
    assign ctrl_wb_src    = ctrl_q.wb_src;
    assign ctrl_alu_op    = ctrl_q.alu_op;
    assign ctrl_alu_src1  = ctrl_q.alu_src1;
    assign ctrl_alu_src2  = ctrl_q.alu_src2;
    assign ctrl_reg_write = ctrl_q.reg_write;
    assign ctrl_illegal   = ctrl_q.illegal;
    assign ctrl_rd        = ctrl_q.rd;
    assign ctrl_rs1       = ctrl_q.rs1;
    assign ctrl_rs2       = ctrl_q.rs2;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed bench for decode_stage_ctrl: one instance with EN_M = 1 and
// DIV_CYCLES = 4, a second with EN_M = 0 for the illegal-M case.
module tb_decode_stage_ctrl;

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_LW   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] I_ADD2 = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] I_DIV  = 32'h0220C3B3; // div x7,x1,x2
    localparam logic [31:0] I_MUL  = 32'h022081B3; // mul x3,x1,x2
    localparam logic [31:0] I_BEQ  = 32'h00208063; // beq x1,x2,0
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF; // unknown opcode

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ir_in;
    logic        valid_in, stall_in, flush_in;

    logic        ready_out, ctrl_valid, ctrl_jal, ctrl_jalr;
    logic        ctrl_mem_read, ctrl_mem_write, ctrl_alu_src1, ctrl_alu_src2;
    logic        ctrl_reg_write, ctrl_illegal;
    logic [3:0]  ctrl_branch;
    logic [1:0]  ctrl_wb_src;
    logic [4:0]  ctrl_alu_op, ctrl_rd, ctrl_rs1, ctrl_rs2;

    logic        n_ready_out, n_ctrl_valid, n_ctrl_jal, n_ctrl_jalr;
    logic        n_ctrl_mem_read, n_ctrl_mem_write, n_ctrl_alu_src1, n_ctrl_alu_src2;
    logic        n_ctrl_reg_write, n_ctrl_illegal;
    logic [3:0]  n_ctrl_branch;
    logic [1:0]  n_ctrl_wb_src;
    logic [4:0]  n_ctrl_alu_op, n_ctrl_rd, n_ctrl_rs1, n_ctrl_rs2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    decode_stage_ctrl #(.EN_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn), .ir_in(ir_in), .valid_in(valid_in),
        .stall_in(stall_in), .flush_in(flush_in), .ready_out(ready_out),
        .ctrl_valid(ctrl_valid), .ctrl_branch(ctrl_branch), .ctrl_jal(ctrl_jal),
        .ctrl_jalr(ctrl_jalr), .ctrl_mem_read(ctrl_mem_read),
        .ctrl_mem_write(ctrl_mem_write), .ctrl_wb_src(ctrl_wb_src),
        .ctrl_alu_op(ctrl_alu_op), .ctrl_alu_src1(ctrl_alu_src1),
        .ctrl_alu_src2(ctrl_alu_src2), .ctrl_reg_write(ctrl_reg_write),
        .ctrl_illegal(ctrl_illegal), .ctrl_rd(ctrl_rd), .ctrl_rs1(ctrl_rs1),
        .ctrl_rs2(ctrl_rs2)
    );

    decode_stage_ctrl #(.EN_M(1'b0), .MUL_CYCLES(1), .DIV_CYCLES(4)) dut_nom (
        .clk(clk), .rstn(rstn), .ir_in(ir_in), .valid_in(valid_in),
        .stall_in(stall_in), .flush_in(flush_in), .ready_out(n_ready_out),
        .ctrl_valid(n_ctrl_valid), .ctrl_branch(n_ctrl_branch), .ctrl_jal(n_ctrl_jal),
        .ctrl_jalr(n_ctrl_jalr), .ctrl_mem_read(n_ctrl_mem_read),
        .ctrl_mem_write(n_ctrl_mem_write), .ctrl_wb_src(n_ctrl_wb_src),
        .ctrl_alu_op(n_ctrl_alu_op), .ctrl_alu_src1(n_ctrl_alu_src1),
        .ctrl_alu_src2(n_ctrl_alu_src2), .ctrl_reg_write(n_ctrl_reg_write),
        .ctrl_illegal(n_ctrl_illegal), .ctrl_rd(n_ctrl_rd), .ctrl_rs1(n_ctrl_rs1),
        .ctrl_rs2(n_ctrl_rs2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic v);
        ir_in    = ir;
        valid_in = v;
        #1;
    endtask

    initial begin
        rstn = 1'b0; ir_in = '0; valid_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        #3;
        check("rst_valid", ctrl_valid, 0);
        check("rst_alu_op", ctrl_alu_op, 0);
        check("rst_rd", ctrl_rd, 0);
        check("rst_ready", ready_out, 1);
        @(negedge clk);
        rstn = 1'b1;

        // add x3,x1,x2
        drive(I_ADD, 1'b1);
        check("add_ready_pre", ready_out, 1);
        tick();
        check("add_valid", ctrl_valid, 1);
        check("add_alu_op", ctrl_alu_op, 5'b00001);
        check("add_reg_write", ctrl_reg_write, 1);
        check("add_alu_src2", ctrl_alu_src2, 0);
        check("add_rd", ctrl_rd, 3);
        check("add_rs1", ctrl_rs1, 1);
        check("add_rs2", ctrl_rs2, 2);
        check("add_ready", ready_out, 1);

        // stall held two cycles with another instruction waiting
        stall_in = 1'b1;
        drive(I_LW, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check("stall_ready", ready_out, 0);
            tick();
            check("stall_valid", ctrl_valid, 1);
            check("stall_rd", ctrl_rd, 3);
            check("stall_alu_op", ctrl_alu_op, 5'b00001);
        end
        stall_in = 1'b0;
        drive(32'h0, 1'b0);
        tick();
        check("idle_bubble", ctrl_valid, 0);

        // lw then dependent add: one interlock bubble
        drive(I_LW, 1'b1);
        tick();
        check("lw_valid", ctrl_valid, 1);
        check("lw_wb_src", ctrl_wb_src, 2'b01);
        check("lw_mem_read", ctrl_mem_read, 1);
        check("lw_reg_write", ctrl_reg_write, 1);
        check("lw_alu_src2", ctrl_alu_src2, 1);
        check("lw_rd", ctrl_rd, 5);
        drive(I_ADD2, 1'b1);
        check("lu_ready", ready_out, 0);
        tick();
        check("lu_bubble", ctrl_valid, 0);
        check("lu_ready_after", ready_out, 1);
        tick();
        check("lu_add_valid", ctrl_valid, 1);
        check("lu_add_rd", ctrl_rd, 6);
        check("lu_add_wb_src", ctrl_wb_src, 2'b00);

        // mul with and without the M extension
        drive(I_MUL, 1'b1);
        check("mul_ready_pre", ready_out, 1);
        tick();
        check("mul_alu_op", ctrl_alu_op, 5'b10000);
        check("mul_illegal", ctrl_illegal, 0);
        check("mul_reg_write", ctrl_reg_write, 1);
        check("mul_ready", ready_out, 1);
        check("nom_valid", n_ctrl_valid, 1);
        check("nom_illegal", n_ctrl_illegal, 1);
        check("nom_reg_write", n_ctrl_reg_write, 0);
        check("nom_ready", n_ready_out, 1);

        // branch and unknown opcode
        drive(I_BEQ, 1'b1);
        tick();
        check("beq_branch", ctrl_branch, 4'b1000);
        check("beq_alu_op", ctrl_alu_op, 5'b00000);
        check("beq_reg_write", ctrl_reg_write, 0);
        drive(I_BAD, 1'b1);
        tick();
        check("bad_valid", ctrl_valid, 1);
        check("bad_illegal", ctrl_illegal, 1);
        check("bad_reg_write", ctrl_reg_write, 0);
        check("bad_mem_read", ctrl_mem_read, 0);
        check("bad_mem_write", ctrl_mem_write, 0);

        // div with DIV_CYCLES = 4: three busy cycles, then next issues
        drive(I_DIV, 1'b1);
        tick();
        check("div_valid", ctrl_valid, 1);
        check("div_alu_op", ctrl_alu_op, 5'b10100);
        check("div_rd", ctrl_rd, 7);
        drive(I_ADD, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("div_busy_ready", ready_out, 0);
            tick();
            check("div_busy_valid", ctrl_valid, 0);
        end
        check("div_done_ready", ready_out, 1);
        tick();
        check("div_next_valid", ctrl_valid, 1);
        check("div_next_rd", ctrl_rd, 3);

        // flush in the second busy cycle of a div
        drive(I_DIV, 1'b1);
        tick();
        drive(I_ADD, 1'b1);
        tick();
        check("fl_busy_ready", ready_out, 0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        #1;
        check("fl_valid", ctrl_valid, 0);
        check("fl_ready", ready_out, 1);
        tick();
        check("fl_next_valid", ctrl_valid, 1);
        check("fl_next_rd", ctrl_rd, 3);

        // asynchronous reset in the middle of a div
        drive(I_DIV, 1'b1);
        tick();
        check("rd_div_valid", ctrl_valid, 1);
        drive(32'h0, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        check("ar_valid", ctrl_valid, 0);
        check("ar_alu_op", ctrl_alu_op, 0);
        check("ar_rd", ctrl_rd, 0);
        check("ar_reg_write", ctrl_reg_write, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("ar_ready", ready_out, 1);
        drive(I_ADD, 1'b1);
        tick();
        check("ar_next_valid", ctrl_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
